// File: rtl/multiplicador_pkg.sv
// Shared constants for the 4-bit shift-and-add multiplier: operand width,
// iteration count and FSM state codes.
package multiplicador_pkg;

  localparam int ANCHO       = 4;
  localparam int ITERACIONES = 4;
  localparam int CONT_W      = 3;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    CALCULO = 2'b01,
    FIN     = 2'b10
  } estado_t;

endpackage

// File: rtl/multiplicador_secuencial_if.sv
// Start/operand/result bundle between a requester (master) and the
// sequential multiplier (slave).
interface multiplicador_secuencial_if;
  import multiplicador_pkg::*;

  logic                 inicio;
  logic [ANCHO-1:0]     a;
  logic [ANCHO-1:0]     b;
  logic                 listo;
  logic                 hecho;
  logic [2*ANCHO-1:0]   producto;

  modport master (output inicio, a, b, input listo, hecho, producto);
  modport slave  (input inicio, a, b, output listo, hecho, producto);

endinterface

// File: rtl/multiplicador_secuencial_sumador.sv
// Plain 4-bit ripple adder with carry in/out; the multiplier uses it with
// cin tied low and cout feeding the partial-product carry bit.
module Sumador4Bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/multiplicador_secuencial.sv
// Unsigned 4x4 shift-and-add multiplier: one conditional add per clock,
// four iterations, one-cycle hecho strobe, registered 8-bit product.
module multiplicador_secuencial #(
  parameter int ANCHO = multiplicador_pkg::ANCHO
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multiplicador_secuencial_if.slave  bus
);
  import multiplicador_pkg::*;

  estado_t             estado, estado_sig;
  logic [ANCHO-1:0]    m, q, acc;
  logic [CONT_W-1:0]   cont;
  logic [ANCHO-1:0]    suma;
  logic                c_suma;
  logic [ANCHO:0]      parcial;
  logic [ANCHO-1:0]    acc_sig, q_sig;
  logic                ultima;
  logic [2*ANCHO-1:0]  producto;

  Sumador4Bits u_sumador (
    .a    (acc),
    .b    (m),
    .cin  (1'b0),
    .s    (suma),
    .cout (c_suma)
  );

  // {c,acc} is kept as one 5-bit value so the carry shifts into acc's MSB
  always_comb begin
    parcial = q[0] ? {c_suma, suma} : {1'b0, acc};
    acc_sig = parcial[ANCHO:1];
    q_sig   = {parcial[0], q[ANCHO-1:1]};
  end

  assign ultima = (cont == CONT_W'(ITERACIONES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (bus.inicio) estado_sig = CALCULO;
      CALCULO: if (ultima)     estado_sig = FIN;
      FIN:                     estado_sig = REPOSO;
      default:                 estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m        <= '0;
      q        <= '0;
      acc      <= '0;
      cont     <= '0;
      producto <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (bus.inicio) begin
            m    <= bus.a;
            q    <= bus.b;
            acc  <= '0;
            cont <= '0;
          end
        end
        CALCULO: begin
          acc  <= acc_sig;
          q    <= q_sig;
          cont <= cont + CONT_W'(1);
          if (ultima) producto <= {acc_sig, q_sig};
        end
        default: ;
      endcase
    end
  end

  assign bus.listo    = (estado == REPOSO);
  assign bus.hecho    = (estado == FIN);
  assign bus.producto = producto;

endmodule
